seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator. It is the next generation of the team's 4-bit combinational gt/eq/sm comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and terminates early on the first differing digit.
- Supports unsigned and two's-complement signed modes.
- Uses a start/busy/done handshake. It serves datapaths where a full-width combinational compare would break timing.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 4, bits compared per clock cycle. Must be ≥1 and ≤WIDTH.
- NDIG (localparam), WIDTH/DIGIT, number of digits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a compare; sampled only when busy=0
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
- A  input  WIDTH  operand A; sampled with start
- B  input  WIDTH  operand B; sampled with start
- busy  output  1  high while a compare is in progress or completing (state != IDLE)
- done  output  1  one-cycle pulse: result valid and updated
- gt  output  1  A > B
- eq  output  1  A == B
- sm  output  1  A < B

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, gt=0, eq=0, sm=0.
  - Operand registers and digit counter cleared.
  - Takes effect immediately, including mid-compare. The in-flight compare is discarded and no done is issued.
- States: IDLE, CMP, DONE.
- IDLE:
  - On a clk edge with start=1: capture A, B and signed_mode into shift registers; digit index=0; go to CMP.
  - In signed mode the MSB of both captured operands is inverted, which maps two's-complement order onto unsigned order.
  - gt/eq/sm keep their previous values.
- CMP:
  - Each edge compares the top DIGIT bits of the A and B shift registers (unsigned), then shifts both left by DIGIT.
  - If the digits differ: gt = (digitA > digitB), sm = (digitA < digitB), eq=0; go to DONE.
  - If the digits are equal and this is digit NDIG-1: eq=1, gt=0, sm=0; go to DONE.
  - Otherwise: increment the digit index and stay in CMP.
- DONE: done=1 for exactly this cycle, then unconditionally to IDLE on the next edge.
- Latency:
  - Start is sampled at edge 0. A decision on digit k (0-based) is registered at edge k+1.
  - done is high during the cycle following edge k+1.
  - Minimum start-to-done is 1 cycle (after edge 1). Maximum is NDIG cycles (equal operands).
  - Next start is accepted at the edge that ends DONE at the earliest? No: busy=1 during DONE, so start is accepted no sooner than the first IDLE cycle.
- start while busy=1 (CMP or DONE): ignored, no queuing. A/B/signed_mode changes during busy have no effect.
- Outputs:
  - gt/eq/sm are registered and update only at the decision edge.
  - They hold until the next decision, so they are stable and one-hot from the first done onward.
  - After reset and before the first done they are all 0.
- DIGIT=WIDTH degenerates to a single-cycle compare: done 1 cycle after start.

Test Plan (WIDTH=16, DIGIT=4):
1. Unsigned, A=0x1234, B=0x1234, start for 1 cycle -> busy rises, done pulses 4 cycles after the start edge, eq=1, gt=0, sm=0.
2. Unsigned, A=0x5000, B=0x3FFF -> decided on digit 0, done 1 cycle after start, gt=1, eq=0, sm=0. Then A=0x0002, B=0x0008 -> decided on digit 3, done after 4 cycles, sm=1.
3. A=0xFFFF, B=0x0001: signed_mode=1 -> sm=1 (−1 < 1). Repeat with signed_mode=0 -> gt=1. Also A=0x8000, B=0x7FFF, signed -> sm=1.
4. Start asserted continuously, with A/B changed every cycle during CMP -> exactly one done per compare. Result reflects the operands captured at the accepted start. Next compare begins only after busy falls.
5. rst_n pulled low asynchronously (mid-cycle) during CMP of A=0x1234, B=0x1235 -> busy/done/gt/eq/sm go 0 immediately, no done pulse. After release, a new start with A=0x0001, B=0x0001 yields eq=1 after 4 cycles.
6. Sweep random A/B pairs in both modes against a combinational reference model -> gt/eq/sm match and are one-hot at every done. Start-to-done latency = (first differing digit index + 1), or 4 when equal.

Source files
------------

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks two operands MSB-first, DIGIT bits per
// clock, and stops at the first differing digit. Signed operands are compared by
// flipping both MSBs at capture, which turns two's-complement order into unsigned order.
module seq_mag_comparator #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             sm
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIG - 1);
   localparam logic [WIDTH-1:0] MsbMask = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCmp, StDone} state_t;

   state_t            state;
   logic [WIDTH-1:0]  a_sh;
   logic [WIDTH-1:0]  b_sh;
   logic [IdxW-1:0]   dig_idx;
   logic [DIGIT-1:0]  a_dig;
   logic [DIGIT-1:0]  b_dig;

   // Current digit under comparison is always the top of each shift register.
   always_comb begin
      a_dig = a_sh[WIDTH-1 -: DIGIT];
      b_dig = b_sh[WIDTH-1 -: DIGIT];
   end

   // Control FSM with registered busy/done and result flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= StIdle;
         a_sh    <= '0;
         b_sh    <= '0;
         dig_idx <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         gt      <= 1'b0;
         eq      <= 1'b0;
         sm      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  a_sh    <= signed_mode ? (A ^ MsbMask) : A;
                  b_sh    <= signed_mode ? (B ^ MsbMask) : B;
                  dig_idx <= '0;
                  busy    <= 1'b1;
                  state   <= StCmp;
               end
            end
            StCmp: begin
               a_sh <= a_sh << DIGIT;
               b_sh <= b_sh << DIGIT;
               if (a_dig != b_dig) begin
                  gt    <= (a_dig > b_dig);
                  sm    <= (a_dig < b_dig);
                  eq    <= 1'b0;
                  done  <= 1'b1;
                  state <= StDone;
               end else if (dig_idx == LastIdx) begin
                  gt    <= 1'b0;
                  sm    <= 1'b0;
                  eq    <= 1'b1;
                  done  <= 1'b1;
                  state <= StDone;
               end else begin
                  dig_idx <= dig_idx + IdxW'(1);
               end
            end
            StDone: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator (WIDTH=16, DIGIT=4): directed vectors with literal
// expectations plus a latency/result model checked against the outputs every cycle.
module tb_seq_mag_comparator;

   localparam int WIDTH = 16;
   localparam int DIGIT = 4;
   localparam int NDIG  = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start = 1'b0;
   logic             signed_mode = 1'b0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             busy, done, gt, eq, sm;

   int checks = 0;
   int errors = 0;

   seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_mode (signed_mode),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .gt          (gt),
      .eq          (eq),
      .sm          (sm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result {gt,eq,sm} from plain integer comparison.
   function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic s);
      if (s) begin
         if ($signed(a) > $signed(b)) return 3'b100;
         if ($signed(a) < $signed(b)) return 3'b001;
      end else begin
         if (a > b) return 3'b100;
         if (a < b) return 3'b001;
      end
      return 3'b010;
   endfunction

   // Cycles from start edge to done: index of the digit holding the highest differing bit + 1.
   // Sign inversion flips the same bit in both operands, so it cannot move that position.
   function automatic int lat_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] x;
      x = a ^ b;
      if (x == '0) return NDIG;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (x[i]) return (WIDTH - 1 - i) / DIGIT + 1;
      end
      return NDIG;
   endfunction

   // Transaction-level model: countdown of the expected latency from each accepted start.
   logic       m_busy = 1'b0, m_done = 1'b0;
   logic [2:0] m_res = 3'b000, p_res = 3'b000;
   int         m_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= 3'b000;
         m_cnt  <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
         m_busy <= 1'b0;
      end else if (m_busy) begin
         if (m_cnt == 1) begin
            m_done <= 1'b1;
            m_res  <= p_res;
         end
         m_cnt <= m_cnt - 1;
      end else if (start) begin
         m_busy <= 1'b1;
         m_cnt  <= lat_of(A, B);
         p_res  <= ref_cmp(A, B, signed_mode);
      end
   end

   // Every-cycle comparison against the model, on the falling edge.
   always @(negedge clk) begin
      chk("cyc_busy", int'(busy), int'(m_busy));
      chk("cyc_done", int'(done), int'(m_done));
      chk("cyc_res", int'({gt, eq, sm}), int'(m_res));
      if (done) chk("cyc_onehot", $countones({gt, eq, sm}), 1);
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   // One compare with literal expectations; operands are scrambled after capture.
   task automatic do_cmp(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic [2:0] exp_res, input int exp_lat);
      int cyc;
      wait_idle();
      A = a; B = b; signed_mode = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A = WIDTH'($urandom); B = WIDTH'($urandom); signed_mode = ~s;
      chk({name, "_busy"}, int'(busy), 1);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({name, "_lat"}, cyc, exp_lat);
      chk({name, "_res"}, int'({gt, eq, sm}), int'(exp_res));
      @(posedge clk); #1;
      chk({name, "_idle"}, int'(busy), 0);
      chk({name, "_hold"}, int'({gt, eq, sm}), int'(exp_res));
   endtask

   initial begin
      int cyc;
      logic [WIDTH-1:0] ra, rb;
      rst_n = 1'b0;
      #22 rst_n = 1'b1;
      #1;
      chk("reset_state", int'({busy, done, gt, eq, sm}), 0);

      // Pin the model against hand-computed values.
      chk("pin_lat_eq", lat_of(16'h1234, 16'h1234), 4);
      chk("pin_lat_d3", lat_of(16'h0002, 16'h0008), 4);
      chk("pin_lat_d0", lat_of(16'h5000, 16'h3FFF), 1);
      chk("pin_ref_s", int'(ref_cmp(16'hFFFF, 16'h0001, 1'b1)), 3'b001);
      chk("pin_ref_u", int'(ref_cmp(16'hFFFF, 16'h0001, 1'b0)), 3'b100);

      @(posedge clk); #1;
      do_cmp("t1_eq", 16'h1234, 16'h1234, 1'b0, 3'b010, 4);
      do_cmp("t2_gt", 16'h5000, 16'h3FFF, 1'b0, 3'b100, 1);
      do_cmp("t2_sm", 16'h0002, 16'h0008, 1'b0, 3'b001, 4);
      do_cmp("t3_s_m1", 16'hFFFF, 16'h0001, 1'b1, 3'b001, 1);
      do_cmp("t3_u_ff", 16'hFFFF, 16'h0001, 1'b0, 3'b100, 1);
      do_cmp("t3_s_min", 16'h8000, 16'h7FFF, 1'b1, 3'b001, 1);
      do_cmp("t3_d2", 16'h12A0, 16'h1250, 1'b0, 3'b100, 3);

      // Start held high with operands changing every cycle.
      wait_idle();
      A = 16'h1234; B = 16'h1234; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      A = WIDTH'($urandom); B = WIDTH'($urandom);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         A = WIDTH'($urandom); B = WIDTH'($urandom);
         cyc++;
      end
      chk("t4_lat", cyc, 4);
      chk("t4_res", int'({gt, eq, sm}), 3'b010);
      @(posedge clk); #1;
      chk("t4_idle_gap", int'(busy), 0);
      @(posedge clk); #1;
      chk("t4_restart", int'(busy), 1);
      start = 1'b0;
      wait_idle();

      // Asynchronous reset in the middle of a compare.
      @(posedge clk); #1;
      A = 16'h1234; B = 16'h1235; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_now", int'({busy, done, gt, eq, sm}), 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("t5_no_done", int'({busy, done}), 0);
      end
      do_cmp("t5_after", 16'h0001, 16'h0001, 1'b0, 3'b010, 4);

      // Random sweep in both modes, with shared prefixes to spread latency.
      for (int i = 0; i < 40; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         if (i % 3 == 0) rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
         if (i % 7 == 0) rb = ra;
         do_cmp("t6_rand", ra, rb, i[0], ref_cmp(ra, rb, i[0]), lat_of(ra, rb));
      end

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
